// File: rtl/key_evolution.sv
// Purpose : Anubis key-evolution sequencer. Latches K^0 on start, then derives
//           K^1..K^12 = sigma[c^r](theta(pi(gamma(K^(r-1))))), one key per 16-cycle window.
// Latency : K^0 one cycle after start; K^(r+1) on each counter 15->0 wrap; done at T+208.
// Backpressure: none. start is ignored while a run is active.
// Ports   : clk, reset (async, active-high), start, cipher_key[127:0] in;
//           evolutioned_key[127:0], round_num[3:0], counter[3:0], load_key, busy, done out.
module key_evolution #(
  parameter int ROUNDS = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic [127:0] evolutioned_key,
  output logic [3:0]   round_num,
  output logic [3:0]   counter,
  output logic         load_key,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST = 4'(ROUNDS);

  // Anubis S-box, entry x at bits [2047-8x -: 8]. It is an involution.
  localparam logic [2047:0] SBOX = {
    128'ha7d3e671_d0ac4d79_3ac991fc_1e4754bd,
    128'h8ca57afb_63b8ddd4_e5b3c5be_a9880ca2,
    128'h39df29da_2ba8cb4c_4b22aa24_4170a6f9,
    128'h5ae2b036_7de433ff_6020088b_5eab7f78,
    128'h7c2c57d2_dc6d7e0d_5394c328_27065fad,
    128'h675c5548_0e52ea42_5b5d3058_51593c4e,
    128'h388a7214_e7c6de50_8e92d177_93459ace,
    128'h2d0362b6_b9bf966b_3f0712ae_4034463e,
    128'hdbcfeccc_c1a1c0d6_1df4613b_10d868a0,
    128'hb10a696c_49fa76c4_9e9b6e99_c2b798bc,
    128'h8f851fb4_f8112e00_251c2a3d_054f7bb2,
    128'h3290af19_a3f7739d_1574eeca_9f0f1b75,
    128'h86849c4a_971a65f6_ed09bb26_83eb6f81,
    128'h046a4301_17e187f5_8de32380_44166621,
    128'hfed531d9_35180264_f2f156cd_82c8baf0,
    128'hefe9e8fd_89d7c7b5_a42f9513_0bf3e037
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q;
  logic [127:0] key_q, g_q, t_q;
  logic [127:0] g_d, t_d, key_d;
  logic [3:0]   round_q, cnt_q;
  logic         load_q, busy_q, done_q;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  // GF(2^8) multiply by 2, reduction polynomial 0x11D.
  function automatic logic [7:0] x2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1d : 8'h00);
  endfunction

  function automatic logic [7:0] x4(input logic [7:0] b);
    return x2(x2(b));
  endfunction

  function automatic logic [7:0] x6(input logic [7:0] b);
    return x4(b) ^ x2(b);
  endfunction

  // gamma then pi: output (i,j) takes the substituted byte from row (i-j) mod 4.
  function automatic logic [127:0] gamma_pi(input logic [127:0] a);
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        b[127-8*(4*i+j) -: 8] = sbox(a[127-8*(4*((i-j)&3)+j) -: 8]);
      end
    end
    return b;
  endfunction

  // theta: each row times had(01,02,04,06), H[k][j] = h[k xor j].
  function automatic logic [127:0] theta(input logic [127:0] a);
    logic [127:0] b;
    logic [7:0]   a0, a1, a2, a3;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      a0 = a[127-32*i -: 8];
      a1 = a[119-32*i -: 8];
      a2 = a[111-32*i -: 8];
      a3 = a[103-32*i -: 8];
      b[127-32*i -: 8] = a0     ^ x2(a1) ^ x4(a2) ^ x6(a3);
      b[119-32*i -: 8] = x2(a0) ^ a1     ^ x6(a2) ^ x4(a3);
      b[111-32*i -: 8] = x4(a0) ^ x6(a1) ^ a2     ^ x2(a3);
      b[103-32*i -: 8] = x6(a0) ^ x4(a1) ^ x2(a2) ^ a3;
    end
    return b;
  endfunction

  // c^(r+1): row 0 byte j = S[4r+j], other rows zero.
  function automatic logic [127:0] rcon(input logic [3:0] r);
    logic [127:0] c;
    c = '0;
    for (int j = 0; j < 4; j++) begin
      c[127-8*j -: 8] = sbox({2'b00, r, 2'(j)});
    end
    return c;
  endfunction

  assign g_d   = gamma_pi(key_q);
  assign t_d   = theta(g_q);
  assign key_d = t_q ^ rcon(round_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      g_q     <= '0;
      t_q     <= '0;
      round_q <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            key_q   <= cipher_key;
            round_q <= '0;
            cnt_q   <= '0;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          cnt_q  <= cnt_q + 4'd1;
          // Registered so the pulse lands on counter==15 of the last window.
          done_q <= (round_q == LAST) && (cnt_q == 4'd14);
          if (round_q < LAST) begin
            // Three-stage evolution spread over the window keeps each stage's logic shallow.
            if (cnt_q == 4'd4) g_q <= g_d;
            if (cnt_q == 4'd5) t_q <= t_d;
            if (cnt_q == 4'd15) begin
              key_q   <= key_d;
              round_q <= round_q + 4'd1;
            end
          end else if (cnt_q == 4'd15) begin
            // Final window: keep K^12 and round_num, drop back to idle.
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign evolutioned_key = key_q;
  assign round_num       = round_q;
  assign counter         = cnt_q;
  assign load_key        = load_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_key_evolution.sv
module tb_key_evolution;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] cipher_key;
  logic [127:0] evolutioned_key;
  logic [3:0]   round_num;
  logic [3:0]   counter;
  logic         load_key;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  typedef struct {
    string        name;
    logic [127:0] key;
    bit           k1_known;
    logic [127:0] k1;
    bit           inj;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  key_evolution #(.ROUNDS(12)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cipher_key(cipher_key),
    .evolutioned_key(evolutioned_key),
    .round_num(round_num),
    .counter(counter),
    .load_key(load_key),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [2047:0] sbox_bits = {
    128'ha7d3e671_d0ac4d79_3ac991fc_1e4754bd,
    128'h8ca57afb_63b8ddd4_e5b3c5be_a9880ca2,
    128'h39df29da_2ba8cb4c_4b22aa24_4170a6f9,
    128'h5ae2b036_7de433ff_6020088b_5eab7f78,
    128'h7c2c57d2_dc6d7e0d_5394c328_27065fad,
    128'h675c5548_0e52ea42_5b5d3058_51593c4e,
    128'h388a7214_e7c6de50_8e92d177_93459ace,
    128'h2d0362b6_b9bf966b_3f0712ae_4034463e,
    128'hdbcfeccc_c1a1c0d6_1df4613b_10d868a0,
    128'hb10a696c_49fa76c4_9e9b6e99_c2b798bc,
    128'h8f851fb4_f8112e00_251c2a3d_054f7bb2,
    128'h3290af19_a3f7739d_1574eeca_9f0f1b75,
    128'h86849c4a_971a65f6_ed09bb26_83eb6f81,
    128'h046a4301_17e187f5_8de32380_44166621,
    128'hfed531d9_35180264_f2f156cd_82c8baf0,
    128'hefe9e8fd_89d7c7b5_a42f9513_0bf3e037
  };

  function automatic logic [7:0] sb_lookup(input logic [7:0] x);
    return sbox_bits[2047 - 8*int'(x) -: 8];
  endfunction

  // Generic shift-and-add GF(2^8) multiply, polynomial 0x11D.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1d) : (aa << 1);
    end
    return p;
  endfunction

  // Reference round: K^r from K^(r-1), computed on a byte matrix.
  function automatic logic [127:0] model_next(input logic [127:0] k, input int r);
    logic [7:0]   m [4][4];
    logic [7:0]   p [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   h [4];
    logic [127:0] o;
    h = '{8'h01, 8'h02, 8'h04, 8'h06};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = sb_lookup(k[127-8*(4*i+j) -: 8]);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        p[(i+j)%4][j] = m[i][j];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        t[i][j] = 8'h00;
        for (int c = 0; c < 4; c++) t[i][j] = t[i][j] ^ gmul(p[i][c], h[c ^ j]);
      end
    for (int j = 0; j < 4; j++) t[0][j] = t[0][j] ^ sb_lookup(8'(4*(r-1)+j));
    o = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        o[127-8*(4*i+j) -: 8] = t[i][j];
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_expected(input logic [127:0] k);
    exp_t         e;
    logic [127:0] kk;
    kk    = k;
    e.rnd = 4'd0;
    e.key = kk;
    sb.push_back(e);
    for (int r = 1; r <= 12; r++) begin
      kk    = model_next(kk, r);
      e.rnd = 4'(r);
      e.key = kk;
      sb.push_back(e);
    end
  endtask

  // Scoreboard: every window start pops the next expected key.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && load_key && counter == 4'd0) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 128'd1, 128'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("sb_key_r%0d", e.rnd), evolutioned_key, e.key);
        check($sformatf("sb_round_r%0d", e.rnd), 128'(round_num), 128'(e.rnd));
      end
    end
  end

  // Called just after a falling edge; drives start for this cycle and walks 209 cycles.
  task automatic do_run(input vec_t v);
    int bad;
    start      = 1'b1;
    cipher_key = v.key;
    push_expected(v.key);
    bad = 0;
    for (int cyc = 1; cyc <= 209; cyc++) begin
      @(negedge clk);
      start      = 1'b0;
      cipher_key = v.key;
      if (cyc <= 208) begin
        if (counter != 4'((cyc-1) % 16) || round_num != 4'((cyc-1) / 16) ||
            !load_key || !busy || done != (cyc == 208)) bad++;
      end else begin
        if (counter != 4'd0 || round_num != 4'd12 || load_key || busy || done) bad++;
      end
      if (cyc == 1) check({v.name, "_k0"}, evolutioned_key, v.key);
      if (cyc == 1) check({v.name, "_cnt0_at_T1"}, 128'(counter), 128'd0);
      if (cyc == 17 && v.k1_known) check({v.name, "_k1_table"}, evolutioned_key, v.k1);
      if (cyc == 207) check({v.name, "_no_early_done"}, 128'(done), 128'd0);
      if (cyc == 208) check({v.name, "_done_T208"}, 128'(done), 128'd1);
      if (cyc == 209) check({v.name, "_idle_T209"}, 128'({load_key, busy, done}), 128'd0);
      if (cyc == 209) check({v.name, "_k12_held"}, 128'(round_num), 128'd12);
      if (v.inj && (cyc == 3*16 + 5 || cyc == 208)) begin
        start      = 1'b1;
        cipher_key = ~v.key;
      end
    end
    check({v.name, "_pacing_bad_cycles"}, 128'(bad), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vecs[0] = '{"zero",   128'h0, 1'b1, 128'h007441d6_a7a7a7a7_a7a7a7a7_a7a7a7a7, 1'b0};
    vecs[1] = '{"all01",  {16{8'h01}}, 1'b1, 128'h740035a2_d3d3d3d3_d3d3d3d3_d3d3d3d3, 1'b0};
    vecs[2] = '{"allff",  {16{8'hff}}, 1'b1, 128'h90e4d146_37373737_37373737_37373737, 1'b0};
    vecs[3] = '{"golden", 128'h80000000_00000000_00000000_00000000, 1'b0, 128'h0, 1'b0};
    vecs[4] = '{"ignore", 128'h80000000_00000000_00000000_00000000, 1'b0, 128'h0, 1'b1};
    vecs[5] = '{"b2b",    128'h01020304_05060708_090a0b0c_0d0e0f10, 1'b0, 128'h0, 1'b0};

    reset      = 1'b1;
    start      = 1'b0;
    cipher_key = '0;
    repeat (2) @(negedge clk);
    check("rst_key",     evolutioned_key, 128'd0);
    check("rst_round",   128'(round_num), 128'd0);
    check("rst_counter", 128'(counter), 128'd0);
    check("rst_load",    128'(load_key), 128'd0);
    check("rst_busy",    128'(busy), 128'd0);
    check("rst_done",    128'(done), 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // Mid-run asynchronous reset at round 5.
    start      = 1'b1;
    cipher_key = 128'h00112233_44556677_8899aabb_ccddeeff;
    push_expected(cipher_key);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(round_num == 4'd5 && counter == 4'd3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_round5", 128'(n < 200), 128'd1);
    #1 reset = 1'b1;
    sb.delete();
    #1;
    check("midrst_key",     evolutioned_key, 128'd0);
    check("midrst_round",   128'(round_num), 128'd0);
    check("midrst_counter", 128'(counter), 128'd0);
    check("midrst_flags",   128'({load_key, busy, done}), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_rst", 128'({load_key, busy, done, round_num, counter}), 128'd0);

    for (int i = 0; i < 6; i++) do_run(vecs[i]);

    @(negedge clk);
    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
